// File: rtl/rv32i_bus_pkg.sv
// Shared types and constants for the LSU bus master: funct3 codes,
// FSM state encoding and the registered request descriptor.
package rv32i_bus_pkg;

  localparam int unsigned BUS_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Request fields kept after acceptance for the response phase
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] offset;
  } lsu_req_t;

endpackage

// File: rtl/lsu_bus_master_if.sv
// Core request/response and decoder-side bus signals of the LSU bus master.
// master: the LSU block; slave: the core and bus decoder around it.
interface lsu_bus_master_if #(
  parameter int unsigned ADDR_W = 16
);
  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_we;
  logic [2:0]                           req_funct3;
  logic [31:0]                          req_addr;
  logic [31:0]                          req_wdata;
  logic                                 rsp_valid;
  logic [rv32i_bus_pkg::BUS_DATA_W-1:0] rsp_rdata;
  logic                                 rsp_err;
  logic [ADDR_W-1:0]                    bus_addr;
  logic                                 bus_wen;
  logic                                 bus_ren;
  logic [3:0]                           bus_wstrb;
  logic [rv32i_bus_pkg::BUS_DATA_W-1:0] bus_wdata;
  logic [rv32i_bus_pkg::BUS_DATA_W-1:0] bus_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_addr, bus_wen, bus_ren, bus_wstrb, bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_addr, bus_wen, bus_ren, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/load_align.sv
// Load data extraction: picks the byte/half lane and sign- or zero-extends.
module load_align
  import rv32i_bus_pkg::*;
(
  input  logic [BUS_DATA_W-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [BUS_DATA_W-1:0] data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane select, then extension chosen by funct3[2] (1 = unsigned)
  always_comb begin
    byte_c = 8'(rdata >> {offset, 3'b000});
    half_c = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3[1:0])
      2'b00:   data = funct3[2] ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   data = funct3[2] ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus master: turns one RV32I load/store request into one bus
// transaction with byte strobes, lane-replicated write data, fixed-latency
// read capture and load extension.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are rejected
// with rsp_err; otherwise they are force-aligned and proceed.
module lsu_bus_master
  import rv32i_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  lsu_bus_master_if.master  bus
);

  localparam int unsigned CNT_W = 3;

  lsu_state_t              state;
  lsu_req_t                req_q;
  logic [CNT_W-1:0]        cnt;
  logic [BUS_DATA_W-1:0]   ext_c;

  logic                    err_c;
  logic                    f3_err_c;
  logic [ADDR_W-1:0]       addr_al_c;
  logic [3:0]              wstrb_c;
  logic [BUS_DATA_W-1:0]   wdata_c;

  // Request check, alignment and store lane shaping from the live request
  always_comb begin
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: f3_err_c = 1'b0;
      F3_BU, F3_HU:     f3_err_c = bus.req_we;
      default:          f3_err_c = 1'b1;
    endcase
    addr_al_c = bus.req_addr[ADDR_W-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    err_c = ((bus.req_addr >> ADDR_W) != 32'd0) || f3_err_c ||
            ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    err_c = ((bus.req_addr >> ADDR_W) != 32'd0) || f3_err_c;
    if (bus.req_funct3[1:0] == 2'b01) begin
      addr_al_c[0] = 1'b0;
    end else if (bus.req_funct3[1:0] == 2'b10) begin
      addr_al_c[1:0] = 2'b00;
    end
`endif
    case (bus.req_funct3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << addr_al_c[1:0];
        wdata_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wstrb_c = 4'b0011 << {addr_al_c[1], 1'b0};
        wdata_c = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = bus.req_wdata;
      end
    endcase
  end

  load_align u_load_align (
    .rdata  (bus.bus_rdata),
    .offset (req_q.offset),
    .funct3 (req_q.funct3),
    .data   (ext_c)
  );

  // Transaction FSM with registered handshake and bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_q         <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wen   <= 1'b0;
      bus.bus_ren   <= 1'b0;
      bus.bus_wstrb <= '0;
      bus.bus_wdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            req_q.we      <= bus.req_we;
            req_q.funct3  <= bus.req_funct3;
            req_q.offset  <= addr_al_c[1:0];
            if (err_c) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else begin
              state        <= ISSUE;
              bus.bus_addr <= addr_al_c;
              cnt          <= CNT_W'(READ_LAT - 1);
              if (bus.req_we) begin
                bus.bus_wen   <= 1'b1;
                bus.bus_wstrb <= wstrb_c;
                bus.bus_wdata <= wdata_c;
              end else begin
                bus.bus_ren <= 1'b1;
              end
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        ISSUE, WAIT: begin
          bus.bus_wen   <= 1'b0;
          bus.bus_ren   <= 1'b0;
          bus.bus_wstrb <= '0;
          bus.bus_wdata <= '0;
          if (req_q.we || (cnt == '0)) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            if (!req_q.we) begin
              bus.rsp_rdata <= ext_c;
            end
          end else begin
            state <= WAIT;
            cnt   <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: one instance with READ_LAT=1 and one
// with READ_LAT=3 share the request/bus stimulus; use3 selects which one
// receives req_valid and is observed.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use3 = 1'b0;
  logic        rv = 1'b0;
  logic        r_we = 1'b0;
  logic [2:0]  r_f3 = 3'd0;
  logic [31:0] r_addr = '0;
  logic [31:0] r_wdata = '0;
  logic [31:0] rd = '0;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_bus_master_if #(.ADDR_W(16)) i1 ();
  lsu_bus_master_if #(.ADDR_W(16)) i3 ();

  assign i1.req_valid  = rv & ~use3;
  assign i3.req_valid  = rv & use3;
  assign i1.req_we     = r_we;
  assign i3.req_we     = r_we;
  assign i1.req_funct3 = r_f3;
  assign i3.req_funct3 = r_f3;
  assign i1.req_addr   = r_addr;
  assign i3.req_addr   = r_addr;
  assign i1.req_wdata  = r_wdata;
  assign i3.req_wdata  = r_wdata;
  assign i1.bus_rdata  = rd;
  assign i3.bus_rdata  = rd;

  lsu_bus_master #(.ADDR_W(16), .READ_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(i1));
  lsu_bus_master #(.ADDR_W(16), .READ_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(i3));

  logic        m_ready, m_rsp_valid, m_rsp_err, m_wen, m_ren;
  logic [31:0] m_rsp_rdata, m_wdata;
  logic [15:0] m_addr;
  logic [3:0]  m_wstrb;

  assign m_ready     = use3 ? i3.req_ready : i1.req_ready;
  assign m_rsp_valid = use3 ? i3.rsp_valid : i1.rsp_valid;
  assign m_rsp_err   = use3 ? i3.rsp_err   : i1.rsp_err;
  assign m_rsp_rdata = use3 ? i3.rsp_rdata : i1.rsp_rdata;
  assign m_wen       = use3 ? i3.bus_wen   : i1.bus_wen;
  assign m_ren       = use3 ? i3.bus_ren   : i1.bus_ren;
  assign m_wdata     = use3 ? i3.bus_wdata : i1.bus_wdata;
  assign m_wstrb     = use3 ? i3.bus_wstrb : i1.bus_wstrb;
  assign m_addr      = use3 ? i3.bus_addr  : i1.bus_addr;

  // Per-transaction observations gathered by run()
  int          rsp_cyc, wen_cnt, ren_cnt, both_cnt;
  logic        rsp_err_o, ready_k1;
  logic [31:0] rsp_data_o, iss_wdata;
  logic [15:0] iss_addr;
  logic [3:0]  iss_wstrb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request, then watch 10 cycles after the accept edge
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
    int guard;
    guard = 0;
    while (!m_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(m_ready), 32'd1);
    rv = 1'b1; r_we = we; r_f3 = f3; r_addr = a; r_wdata = wd;
    @(negedge clk);
    rv = 1'b0;
    rsp_cyc = 0; wen_cnt = 0; ren_cnt = 0; both_cnt = 0;
    rsp_err_o = 1'b0; rsp_data_o = '0; iss_wdata = '0; iss_addr = '0; iss_wstrb = '0;
    ready_k1 = m_ready;
    for (int k = 1; k <= 10; k++) begin
      if (m_wen || m_ren) begin
        if (wen_cnt == 0 && ren_cnt == 0) begin
          iss_addr = m_addr; iss_wstrb = m_wstrb; iss_wdata = m_wdata;
        end
        if (m_wen) wen_cnt++;
        if (m_ren) ren_cnt++;
        if (m_wen && m_ren) both_cnt++;
      end
      if (m_rsp_valid && rsp_cyc == 0) begin
        rsp_cyc = k; rsp_err_o = m_rsp_err; rsp_data_o = m_rsp_rdata;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic seen_rsp;

    // Reset state
    #12;
    check("rst_ready", 32'(i1.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(i1.rsp_valid), 32'd0);
    check("rst_wen_ren", {30'd0, i1.bus_wen, i1.bus_ren}, 32'd0);
    check("rst_addr", 32'(i1.bus_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SW 0x2004
    run(1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF);
    check("sw_ready_drop", 32'(ready_k1), 32'd0);
    check("sw_addr", 32'(iss_addr), 32'h2004);
    check("sw_wen_cycles", 32'(wen_cnt), 32'd1);
    check("sw_wstrb", 32'(iss_wstrb), 32'hF);
    check("sw_wdata", iss_wdata, 32'hDEAD_BEEF);
    check("sw_rsp_cyc", 32'(rsp_cyc), 32'd2);
    check("sw_rsp_err", 32'(rsp_err_o), 32'd0);
    check("sw_rsp_rdata", rsp_data_o, 32'd0);

    // SB 0x3001
    run(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5);
    check("sb_wstrb", 32'(iss_wstrb), 32'h2);
    check("sb_wdata", iss_wdata, 32'hA5A5_A5A5);
    check("sb_ren_cycles", 32'(ren_cnt), 32'd0);
    check("sb_rsp_cyc", 32'(rsp_cyc), 32'd2);

    // SH 0x3002
    run(1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF);
    check("sh_wstrb", 32'(iss_wstrb), 32'hC);
    check("sh_wdata", iss_wdata, 32'hBEEF_BEEF);

    // Loads with READ_LAT=1
    rd = 32'h80FF_1234;
    run(1'b0, 3'b000, 32'h0000_0003, 32'd0);
    check("lb_rdata", rsp_data_o, 32'hFFFF_FF80);
    check("lb_rsp_cyc", 32'(rsp_cyc), 32'd2);
    check("lb_ren_cycles", 32'(ren_cnt), 32'd1);
    check("lb_wen_cycles", 32'(wen_cnt), 32'd0);
    check("lb_wstrb", 32'(iss_wstrb), 32'd0);
    run(1'b0, 3'b100, 32'h0000_0003, 32'd0);
    check("lbu_rdata", rsp_data_o, 32'h0000_0080);
    run(1'b0, 3'b001, 32'h0000_0002, 32'd0);
    check("lh_rdata", rsp_data_o, 32'hFFFF_80FF);
    check("lh_addr", 32'(iss_addr), 32'h0002);
    run(1'b0, 3'b101, 32'h0000_0002, 32'd0);
    check("lhu_rdata", rsp_data_o, 32'h0000_80FF);

    // Errors
    run(1'b0, 3'b010, 32'h0001_0000, 32'd0);
    check("hi_addr_err", 32'(rsp_err_o), 32'd1);
    check("hi_addr_cyc", 32'(rsp_cyc), 32'd1);
    check("hi_addr_strobes", 32'(wen_cnt + ren_cnt), 32'd0);
    check("hi_addr_rdata", rsp_data_o, 32'd0);
    run(1'b0, 3'b011, 32'h0000_0010, 32'd0);
    check("f3_011_err", 32'(rsp_err_o), 32'd1);
    check("f3_011_cyc", 32'(rsp_cyc), 32'd1);
    run(1'b1, 3'b100, 32'h0000_0010, 32'h55);
    check("store_bu_err", 32'(rsp_err_o), 32'd1);
    check("store_bu_strobes", 32'(wen_cnt + ren_cnt), 32'd0);

    // Misaligned LH 0x0001
    run(1'b0, 3'b001, 32'h0000_0001, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lh_err", 32'(rsp_err_o), 32'd1);
    check("mis_lh_cyc", 32'(rsp_cyc), 32'd1);
    check("mis_lh_strobes", 32'(wen_cnt + ren_cnt), 32'd0);
    check("mis_lh_rdata", rsp_data_o, 32'd0);
`else
    check("mis_lh_err", 32'(rsp_err_o), 32'd0);
    check("mis_lh_addr", 32'(iss_addr), 32'h0000);
    check("mis_lh_cyc", 32'(rsp_cyc), 32'd2);
    check("mis_lh_rdata", rsp_data_o, 32'h0000_1234);
`endif

    // READ_LAT=3 word load
    use3 = 1'b1;
    rd = 32'h1234_5678;
    run(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    check("lw3_ren_cycles", 32'(ren_cnt), 32'd1);
    check("lw3_addr", 32'(iss_addr), 32'h0100);
    check("lw3_rsp_cyc", 32'(rsp_cyc), 32'd4);
    check("lw3_rdata", rsp_data_o, 32'h1234_5678);

    // Reset during WAIT of a READ_LAT=3 load
    while (!m_ready) @(negedge clk);
    rv = 1'b1; r_we = 1'b0; r_f3 = 3'b010; r_addr = 32'h0000_0100;
    @(negedge clk);
    rv = 1'b0;
    check("abort_issue_ren", 32'(m_ren), 32'd1);
    @(negedge clk);
    check("abort_wait_addr", 32'(m_addr), 32'h0100);
    rst = 1'b1;
    #1;
    check("abort_addr_zero", 32'(m_addr), 32'd0);
    check("abort_ren_zero", 32'(m_ren), 32'd0);
    check("abort_ready_zero", 32'(m_ready), 32'd0);
    seen_rsp = m_rsp_valid;
    repeat (2) begin
      @(negedge clk);
      seen_rsp = seen_rsp | m_rsp_valid;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_rsp = seen_rsp | m_rsp_valid;
    end
    check("abort_no_rsp", 32'(seen_rsp), 32'd0);
    check("abort_ready_back", 32'(m_ready), 32'd1);
    run(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D);
    check("post_rst_sw_wdata", iss_wdata, 32'hCAFE_F00D);
    check("post_rst_sw_cyc", 32'(rsp_cyc), 32'd2);
    check("post_rst_sw_err", 32'(rsp_err_o), 32'd0);
    check("post_rst_sw_both", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
